// File: rtl/aes_pkg.sv
// Shared AES definitions: affine constants, the byte-serial engine state type
// and the forward/inverse affine transforms.
package aes_pkg;

  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [7:0] FWD_AFFINE_C = 8'h63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  // b_i = y_(i+2) ^ y_(i+5) ^ y_(i+7) ^ c_i, written as right-rotations of y
  function automatic logic [7:0] inv_affine(input logic [7:0] y);
    logic [7:0] rotr2, rotr5, rotr7;
    rotr2 = {y[1:0], y[7:2]};
    rotr5 = {y[4:0], y[7:5]};
    rotr7 = {y[6:0], y[7]};
    return rotr2 ^ rotr5 ^ rotr7 ^ INV_AFFINE_C;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    logic [7:0] rotl1, rotl2, rotl3, rotl4;
    rotl1 = {b[6:0], b[7]};
    rotl2 = {b[5:0], b[7:6]};
    rotl3 = {b[4:0], b[7:5]};
    rotl4 = {b[3:0], b[7:4]};
    return b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ FWD_AFFINE_C;
  endfunction

endpackage

// File: rtl/GF_MULINV_8.sv
// Combinational multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1,
// computed as a^254 (zero maps to zero).
module GF_MULINV_8 (
  input  logic [7:0] a,
  output logic [7:0] a_inv
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1B) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  logic [7:0] p2_s, p4_s, p8_s, p16_s, p32_s, p64_s, p128_s;

  // 254 = 2+4+8+16+32+64+128: square repeatedly, then multiply the powers
  always_comb begin
    p2_s   = gf_mul(a, a);
    p4_s   = gf_mul(p2_s, p2_s);
    p8_s   = gf_mul(p4_s, p4_s);
    p16_s  = gf_mul(p8_s, p8_s);
    p32_s  = gf_mul(p16_s, p16_s);
    p64_s  = gf_mul(p32_s, p32_s);
    p128_s = gf_mul(p64_s, p64_s);
    a_inv  = gf_mul(gf_mul(gf_mul(p2_s, p4_s), gf_mul(p8_s, p16_s)),
                    gf_mul(gf_mul(p32_s, p64_s), p128_s));
  end

endmodule

// File: rtl/inv_sbox_byte.sv
// One AES inverse S-box byte: inverse affine followed by the field inverter.
module inv_sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] y_i,
  output logic [7:0] s_o
);

  logic [7:0] b_s;

  assign b_s = inv_affine(y_i);

  GF_MULINV_8 u_inv (
    .a     (b_s),
    .a_inv (s_o)
  );

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial InvSubBytes: one column in, four cycles through a single
// inverse S-box, registered column out with a DONE->SUB bypass.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] src_q, src_d;
  logic [31:0] res_q, res_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        idle_q, idle_d;

  logic [1:0]  idx_s;
  logic [7:0]  sel_byte_s;
  logic [7:0]  sub_byte_s;
  logic        accept_s;

  // in_ready is the only output with a combinational input dependency
  assign in_ready  = idle_q | (out_valid_q & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign busy      = busy_q;

  assign idx_s      = (MSB_FIRST != 0) ? (2'd3 - cnt_q) : cnt_q;
  assign sel_byte_s = src_q[{idx_s, 3'b000} +: 8];

  inv_sbox_byte u_sbox (
    .y_i (sel_byte_s),
    .s_o (sub_byte_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    idle_d      = idle_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          src_d   = in_data;
          cnt_d   = 2'd0;
          state_d = SUB;
          busy_d  = 1'b1;
          idle_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
        res_d[{idx_s, 3'b000} +: 8] = sub_byte_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = SUB;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept_s) begin
            src_d   = in_data;
            cnt_d   = 2'd0;
            state_d = SUB;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            idle_d  = 1'b1;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        idle_d      = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight column
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      src_q       <= 32'h0000_0000;
      res_q       <= 32'h0000_0000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      idle_q      <= idle_d;
    end
  end

endmodule
